// File: rtl/buyruk_yukleyici.sv
// Instruction loader: streams words into instruction memory, then releases the core from reset.
// Optional macro YUKLEYICI_SAGLAMA_EN adds a running-sum check against beklenen_toplam.
module buyruk_yukleyici #(
  parameter int unsigned VERI_W   = 32,
  parameter int unsigned DERINLIK = 64,
  localparam int unsigned ADRES_W = $clog2(DERINLIK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               yukle_basla,
  input  logic               giris_gecerli,
  input  logic [VERI_W-1:0]  giris_veri,
  input  logic               giris_son,
`ifdef YUKLEYICI_SAGLAMA_EN
  input  logic [VERI_W-1:0]  beklenen_toplam,
`endif
  output logic               giris_hazir,
  output logic               bb_yaz_en,
  output logic [ADRES_W-1:0] bb_adres,
  output logic [VERI_W-1:0]  bb_veri,
  output logic               cekirdek_rst,
  output logic               yukleme_bitti,
  output logic [ADRES_W:0]   sayac,
  output logic               hata
);

  localparam logic [ADRES_W:0] SonAdres = (ADRES_W + 1)'(DERINLIK - 1);
  localparam logic [ADRES_W:0] TamSayi  = (ADRES_W + 1)'(DERINLIK);

  typedef enum logic [2:0] {
    StBos,
    StYukle,
    StBitir,
    StCalis,
    StHata
  } durum_e;

  durum_e               durum_q, durum_d;
  logic [ADRES_W:0]     sayac_q, sayac_d;
  logic                 yaz_q, yaz_d;
  logic [ADRES_W-1:0]   adres_q, adres_d;
  logic [VERI_W-1:0]    veri_q, veri_d;
  logic                 aktarim;
  logic                 saglama_tamam;

  // A restart pulse masks ready so a word offered in that cycle is never written.
  assign giris_hazir = (durum_q == StYukle) && !yukle_basla;
  assign aktarim     = giris_gecerli && giris_hazir;

`ifdef YUKLEYICI_SAGLAMA_EN
  logic [VERI_W-1:0] toplam_q, toplam_d;

  always_comb begin
    toplam_d = toplam_q;
    if (yukle_basla) begin
      toplam_d = '0;
    end else if (aktarim) begin
      toplam_d = toplam_q + giris_veri;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toplam_q <= '0;
    end else begin
      toplam_q <= toplam_d;
    end
  end

  assign saglama_tamam = (toplam_q == beklenen_toplam);
`else
  assign saglama_tamam = 1'b1;
`endif

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    if (yukle_basla) begin
      durum_d = StYukle;
      sayac_d = '0;
    end else begin
      unique case (durum_q)
        StYukle: begin
          if (aktarim) begin
            if (sayac_q != TamSayi) begin
              sayac_d = sayac_q + 1'b1;
            end
            if (giris_son) begin
              durum_d = StBitir;
            end else if (sayac_q == SonAdres) begin
              durum_d = StHata;
            end
          end
        end
        StBitir: durum_d = saglama_tamam ? StCalis : StHata;
        StBos, StCalis, StHata: ;
        default: durum_d = StBos;
      endcase
    end
  end

  always_comb begin
    yaz_d   = aktarim;
    adres_d = adres_q;
    veri_d  = veri_q;
    if (aktarim) begin
      adres_d = sayac_q[ADRES_W-1:0];
      veri_d  = giris_veri;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q <= StBos;
      sayac_q <= '0;
      yaz_q   <= 1'b0;
      adres_q <= '0;
      veri_q  <= '0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
      yaz_q   <= yaz_d;
      adres_q <= adres_d;
      veri_q  <= veri_d;
    end
  end

  assign bb_yaz_en     = yaz_q;
  assign bb_adres      = adres_q;
  assign bb_veri       = veri_q;
  assign sayac         = sayac_q;
  assign cekirdek_rst  = (durum_q != StCalis);
  assign yukleme_bitti = (durum_q == StCalis);
  assign hata          = (durum_q == StHata);

endmodule
